// File: rtl/int_div_pkg.sv
// Shared definitions for the iterative integer divider and its restoring step.
package int_div_pkg;

  localparam int unsigned W_DEF  = 32;
  localparam int unsigned CW_DEF = 6;

  // Divide-by-zero quotient; callers truncate with W'(DZ_QUOT)
  localparam logic [63:0] DZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DZ   = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] r_i,
  input  logic         q_msb_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] r_o,
  output logic         q_bit_o
);

  logic [W+1:0] trial;

  // Keep the partial remainder's top bit so divisors above 2^(W-1) divide correctly
  always_comb begin
    trial   = {1'b0, r_i, q_msb_i} - {2'b00, d_i};
    q_bit_o = ~trial[W+1];
    r_o     = q_bit_o ? W'(trial) : {r_i[W-2:0], q_msb_i};
  end

endmodule

// File: rtl/iter_int_div.sv
// Iterative restoring divider, one quotient bit per cycle, commit/ack result handshake.
// Define SIGNED_DIV_EN for two's-complement operands (truncating toward zero).
module iter_int_div
  import int_div_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] intA,
  input  logic [W-1:0] intB,
  input  logic         val_op,
  output logic         rdy_op,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         commit,
  input  logic         ack
);

  div_state_e    state_q, state_d;
  logic [W-1:0]  r_q, r_d, q_q, q_d, div_q, div_d;
  logic [W-1:0]  quot_q, quot_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          commit_q, commit_d, rdy_q, rdy_d;

  logic [W-1:0]  mag_a_c, mag_b_c, step_r_c, step_q_c;
  logic          step_qbit_c, neg_quot_c, neg_rem_c;

`ifdef SIGNED_DIV_EN
  logic          sa_q, sa_d, sb_q, sb_d;

  assign mag_a_c    = intA[W-1] ? -intA : intA;
  assign mag_b_c    = intB[W-1] ? -intB : intB;
  assign neg_quot_c = sa_q ^ sb_q;
  assign neg_rem_c  = sa_q;
`else
  assign mag_a_c    = intA;
  assign mag_b_c    = intB;
  assign neg_quot_c = 1'b0;
  assign neg_rem_c  = 1'b0;
`endif

  div_step #(.W(W)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[W-1]),
    .d_i     (div_q),
    .r_o     (step_r_c),
    .q_bit_o (step_qbit_c)
  );

  assign step_q_c = {q_q[W-2:0], step_qbit_c};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (val_op) state_d = (intB == '0) ? DZ : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DZ:      state_d = DONE;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values; results land on entry to DONE
  always_comb begin
    r_d      = r_q;
    q_d      = q_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
`ifdef SIGNED_DIV_EN
    sa_d     = sa_q;
    sb_d     = sb_q;
`endif
    rdy_d    = (state_d == IDLE);
    commit_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (val_op) begin
          r_d   = '0;
          q_d   = mag_a_c;
          div_d = mag_b_c;
          cnt_d = CW'(W - 1);
`ifdef SIGNED_DIV_EN
          sa_d  = intA[W-1];
          sb_d  = intB[W-1];
`endif
        end
      end
      CALC: begin
        r_d = step_r_c;
        q_d = step_q_c;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          quot_d = neg_quot_c ? -step_q_c : step_q_c;
          rem_d  = neg_rem_c  ? -step_r_c : step_r_c;
        end
      end
      DZ: begin
        quot_d = W'(DZ_QUOT);
        rem_d  = neg_rem_c ? -q_q : q_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '0;
      q_q      <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      commit_q <= 1'b0;
      rdy_q    <= 1'b1;
`ifdef SIGNED_DIV_EN
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
`endif
    end else begin
      r_q      <= r_d;
      q_q      <= q_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      commit_q <= commit_d;
      rdy_q    <= rdy_d;
`ifdef SIGNED_DIV_EN
      sa_q     <= sa_d;
      sb_q     <= sb_d;
`endif
    end
  end

  assign rdy_op = rdy_q;
  assign commit = commit_q;
  assign quot   = quot_q;
  assign rem    = rem_q;

endmodule

// File: tb/tb_iter_int_div.sv
// Directed self-checking bench for iter_int_div (unsigned, or signed with SIGNED_DIV_EN).
module tb_iter_int_div;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset, val_op, rdy_op, commit, ack;
  logic [W-1:0] intA, intB, quot, rem;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iter_int_div dut (
    .clk    (clk),
    .reset  (reset),
    .intA   (intA),
    .intB   (intB),
    .val_op (val_op),
    .rdy_op (rdy_op),
    .quot   (quot),
    .rem    (rem),
    .commit (commit),
    .ack    (ack)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    intA   = a;
    intB   = b;
    val_op = 1'b1;
  endtask

  // lat = index of the first edge after the accept edge at which commit is sampled high
  task automatic wait_commit(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      val_op = 1'b0;
      intA   = $urandom;
      intB   = $urandom;
      if (commit) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check_eq("commit_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_ack(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check_eq({tag, "_rdy_after_ack"}, 32'(rdy_op), 32'd1);
    check_eq({tag, "_commit_after_ack"}, 32'(commit), 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input int elat);
    int lat;
    issue(a, b);
    wait_commit(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_quot"}, quot, eq);
    check_eq({tag, "_rem"}, rem, er);
    release_ack(tag);
  endtask

  initial begin
    int lat;
    int acc[2];
    int n_acc, n_com;

    reset = 1'b1; val_op = 1'b0; ack = 1'b0; intA = '0; intB = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_rdy", 32'(rdy_op), 32'd1);
    check_eq("rst_commit", 32'(commit), 32'd0);
    check_eq("rst_quot", quot, 32'd0);
    check_eq("rst_rem", rem, 32'd0);
    reset = 1'b0;

    run_div("basic", 32'd100, 32'd7, 32'd14, 32'd2, LAT);
    run_div("dz", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 2);

    // Back-pressure: result held, new requests refused
    issue(32'hFFFF_FFFF, 32'd1);
    wait_commit(lat);
    check_eq("bp_lat", 32'(lat), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      val_op = 1'b1;
      intA   = 32'd5;
      intB   = 32'd3;
      @(negedge clk);
      check_eq("bp_commit", 32'(commit), 32'd1);
      check_eq("bp_quot", quot, 32'hFFFF_FFFF);
      check_eq("bp_rem", rem, 32'd0);
      check_eq("bp_rdy", 32'(rdy_op), 32'd0);
    end
    val_op = 1'b0;
    release_ack("bp");

    // Reset aborts an in-flight division
    issue(32'd50, 32'd5);
    repeat (5) begin
      @(negedge clk);
      val_op = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_commit", 32'(commit), 32'd0);
    check_eq("midrst_rdy", 32'(rdy_op), 32'd1);
    check_eq("midrst_quot", quot, 32'd0);
    check_eq("midrst_rem", rem, 32'd0);
    run_div("post_rst", 32'd9, 32'd4, 32'd2, 32'd1, LAT);

    // Back-to-back with ack tied high
    acc[0] = 0; acc[1] = 0; n_acc = 0; n_com = 0;
    @(negedge clk);
    ack = 1'b1; intA = 32'd1000; intB = 32'd10; val_op = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (rdy_op && val_op && n_acc < 2) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (commit) begin
        if (n_com == 0) begin
          check_eq("b2b_quot0", quot, 32'd100);
          check_eq("b2b_rem0", rem, 32'd0);
          intA = 32'd7;
          intB = 32'd9;
        end else begin
          check_eq("b2b_quot1", quot, 32'd0);
          check_eq("b2b_rem1", rem, 32'd7);
          val_op = 1'b0;
        end
        n_com++;
      end
      if (n_com >= 2) break;
      @(negedge clk);
    end
    check_eq("b2b_commits", 32'(n_com), 32'd2);
    check_eq("b2b_spacing", 32'(acc[1] - acc[0]), 32'(W + 2));
    @(negedge clk);
    ack = 1'b0;
    check_eq("b2b_rdy_end", 32'(rdy_op), 32'd1);

`ifdef SIGNED_DIV_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, LAT);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, LAT);
    run_div("s_dz_neg", 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2);
`else
    run_div("u_big_2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, LAT);
    run_div("u_7_big", 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, LAT);
    run_div("u_hi_div", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, LAT);
    run_div("u_min_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, LAT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
